// File: rtl/regfile_scoreboard_if.sv
// Register file port bundle: NREAD read ports with busy flags, one write port,
// one reservation port with acceptance, pipeline flush and the busy count.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  rsv_en;
  logic [AW-1:0]         rsv_addr;
  logic                  rsv_ok;
  logic                  flush;
  logic [AW:0]           busy_cnt;

  // master = decode/writeback side, slave = the register file
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, rsv_ok, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, rsv_ok, busy_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard, write-to-read bypass and async clear.
// Reads/rd_busy/rsv_ok are 0-cycle combinational; a busy register refuses new reservations.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = AW + 1;

  logic [XLEN-1:0]       regs [NREGS];
  logic [NREGS-1:0]      busy;
  logic [NREGS-1:0]      busy_nxt;
  logic [CW-1:0]         cnt;
  logic                  wr_act;
  logic                  rsv_ok;
  logic                  rsv_set;
  logic                  cnt_inc;
  logic                  cnt_dec;
  logic [NREAD*XLEN-1:0] rd_data_c;
  logic [NREAD-1:0]      rd_busy_c;
  logic [AW-1:0]         port_addr;
  logic                  port_hit;

  // A busy register can only be re-reserved when this cycle's write retires it.
  always_comb begin
    wr_act  = bus.wr_en && (bus.wr_addr != '0);
    rsv_ok  = rst && bus.rsv_en && !bus.flush &&
              ((bus.rsv_addr == '0) || !busy[bus.rsv_addr] ||
               (bus.wr_en && (bus.wr_addr == bus.rsv_addr)));
    rsv_set = rsv_ok && (bus.rsv_addr != '0);
    cnt_inc = rsv_set && !busy[bus.rsv_addr];
    cnt_dec = wr_act && busy[bus.wr_addr] &&
              !(rsv_set && (bus.rsv_addr == bus.wr_addr));
  end

  always_comb begin
    busy_nxt = busy;
    if (wr_act) begin
      busy_nxt[bus.wr_addr] = 1'b0;
    end
    if (rsv_set) begin
      busy_nxt[bus.rsv_addr] = 1'b1;
    end
    if (bus.flush) begin
      busy_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_nxt;
      if (bus.flush) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(cnt_inc) - CW'(cnt_dec);
      end
    end
  end

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_act) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    port_addr = '0;
    port_hit  = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      port_addr = bus.rd_addr[i*AW +: AW];
      port_hit  = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == port_addr) &&
                  (port_addr != '0);
      if (rst && (port_addr != '0)) begin
        rd_data_c[i*XLEN +: XLEN] = port_hit ? bus.wr_data : regs[port_addr];
        rd_busy_c[i]              = busy[port_addr] && !port_hit;
      end
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.rsv_ok   = rsv_ok;
  assign bus.busy_cnt = cnt;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives two register files (bypass on and off) with identical traffic and
// scores their outputs against an array-based reference model.
module tb_regfile_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;

  logic clk;
  logic rst;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus1 ();
  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus0 ();

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dut_byp (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dut_nobyp (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d1;
    logic [63:0] d0;
    logic [1:0]  b1;
    logic [1:0]  b0;
    logic        ok;
    logic [5:0]  cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: plain array of values and a set of pending registers.
  logic [31:0] mregs [NREGS];
  bit          mbusy [NREGS];

  function automatic void model_clear();
    for (int i = 0; i < NREGS; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(mbusy[i]);
    return n;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a, input bit byp, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (byp && we && wa == a) return wd;
    return mregs[a];
  endfunction

  function automatic logic mbusyq(input logic [4:0] a, input bit byp, input logic we,
                                  input logic [4:0] wa);
    if (a == 0) return 1'b0;
    return mbusy[a] && !(byp && we && wa == a);
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra, input logic fl,
                       input logic [4:0] a0, input logic [4:0] a1, input logic rstv);
    exp_t e;
    logic [4:0] a;
    @(posedge clk);
    #1;
    rst           = rstv;
    bus1.wr_en    = we;  bus0.wr_en    = we;
    bus1.wr_addr  = wa;  bus0.wr_addr  = wa;
    bus1.wr_data  = wd;  bus0.wr_data  = wd;
    bus1.rsv_en   = re;  bus0.rsv_en   = re;
    bus1.rsv_addr = ra;  bus0.rsv_addr = ra;
    bus1.flush    = fl;  bus0.flush    = fl;
    bus1.rd_addr  = {a1, a0};
    bus0.rd_addr  = {a1, a0};
    e.d1 = '0; e.d0 = '0; e.b1 = '0; e.b0 = '0; e.ok = 1'b0; e.cnt = '0;
    if (rstv) begin
      for (int p = 0; p < NREAD; p++) begin
        a = (p == 0) ? a0 : a1;
        e.d1[p*32 +: 32] = mread(a, 1'b1, we, wa, wd);
        e.d0[p*32 +: 32] = mread(a, 1'b0, we, wa, wd);
        e.b1[p]          = mbusyq(a, 1'b1, we, wa);
        e.b0[p]          = mbusyq(a, 1'b0, we, wa);
      end
      e.ok  = re && !fl && (ra == 0 || !mbusy[ra] || (we && wa == ra));
      e.cnt = 6'(pending());
      if (we && wa != 0) begin
        mregs[wa] = wd;
        mbusy[wa] = 1'b0;
      end
      if (e.ok && ra != 0) mbusy[ra] = 1'b1;
      if (fl) begin
        for (int i = 0; i < NREGS; i++) mbusy[i] = 1'b0;
      end
    end else begin
      model_clear();
    end
    q.push_back(e);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] a0);
    drive(1'b1, wa, wd, 1'b0, 5'd0, 1'b0, a0, 5'd0, 1'b1);
  endtask

  task automatic rsv(input logic [4:0] ra, input logic [4:0] a0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, ra, 1'b0, a0, 5'd0, 1'b1);
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, a0, a1, 1'b1);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 9));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd_data_bypass", 64'(bus1.rd_data), e.d1);
      chk("rd_data_nobypass", 64'(bus0.rd_data), e.d0);
      chk("rd_busy_bypass", 64'(bus1.rd_busy), 64'(e.b1));
      chk("rd_busy_nobypass", 64'(bus0.rd_busy), 64'(e.b0));
      chk("rsv_ok_bypass", 64'(bus1.rsv_ok), 64'(e.ok));
      chk("rsv_ok_nobypass", 64'(bus0.rsv_ok), 64'(e.ok));
      chk("busy_cnt_bypass", 64'(bus1.busy_cnt), 64'(e.cnt));
      chk("busy_cnt_nobypass", 64'(bus0.busy_cnt), 64'(e.cnt));
    end
  end

  initial begin
    rst = 1'b0;
    bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0; bus1.rsv_en = 1'b0;
    bus1.rsv_addr = '0; bus1.flush = 1'b0; bus1.rd_addr = '0;
    bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0; bus0.rsv_en = 1'b0;
    bus0.rsv_addr = '0; bus0.flush = 1'b0; bus0.rd_addr = '0;
    model_clear();
    repeat (2) @(posedge clk);

    // Reset check: fill registers and reservations, then clear and read everything.
    for (int i = 1; i < 8; i++) wr(5'(i), 32'h1000_0000 + 32'(i), 5'(i));
    rsv(5'd2, 5'd2);
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 1'b0, 5'd5, 5'd2, 1'b0);
    for (int i = 0; i < NREGS; i += 2) rd(5'(i), 5'(i + 1));

    // Same-cycle write with a read of the same register, then a plain read.
    wr(5'd5, 32'hDEAD_BEEF, 5'd5);
    rd(5'd5, 5'd0);

    // Zero register: write and reserve r0 together.
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    rd(5'd0, 5'd0);

    // Scoreboard: reserve, refused re-reserve, retire.
    rsv(5'd9, 5'd9);
    rsv(5'd9, 5'd9);
    wr(5'd9, 32'h20, 5'd9);
    rd(5'd9, 5'd9);

    // Write and reserve the busy r6 in one cycle.
    rsv(5'd6, 5'd6);
    drive(1'b1, 5'd6, 32'hA, 1'b1, 5'd6, 1'b0, 5'd6, 5'd0, 1'b1);
    rd(5'd6, 5'd0);

    // Flush with a concurrent reservation.
    wr(5'd6, 32'hB, 5'd6);
    rsv(5'd3, 5'd3);
    rsv(5'd4, 5'd4);
    rsv(5'd7, 5'd7);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b1, 5'd3, 5'd4, 1'b1);
    rd(5'd7, 5'd8);

    // Randomised traffic with occasional flushes and mid-run resets.
    for (int n = 0; n < 1500; n++) begin
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'($urandom_range(0, 1)),
            rnd_addr(), 1'($urandom_range(0, 15) == 0), rnd_addr(), rnd_addr(),
            1'($urandom_range(0, 199) != 0));
    end
    rd(5'd0, 5'd1);

    @(posedge clk);
    #1;
    bus1.wr_en = 1'b0; bus1.rsv_en = 1'b0; bus1.flush = 1'b0;
    bus0.wr_en = 1'b0; bus0.rsv_en = 1'b0; bus0.flush = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
